// File: rtl/mcse_ami_outbox_pkg.sv
// Shared types, default sizing and the round-robin pick function for the MCSE->AMI outbox.
// Used by mcse_ami_outbox (optional MCSE_AMI_PRIORITY_EN build flag lives in the top).
package mcse_ami_pkg;

  typedef enum logic {
    AMI_IDLE    = 1'b0,
    AMI_PRESENT = 1'b1
  } ami_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_DEPTH  = 4;
  localparam int MAX_CH     = 32;
  localparam int MAX_CH_W   = 5;

  // First requester at or after ptr, wrapping modulo n; returns ptr when nothing requests.
  function automatic int rr_next(input logic [MAX_CH-1:0] req, input int ptr, input int n);
    int idx;
    int res;
    res = ptr;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (req[idx[MAX_CH_W-1:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mcse_ami_outbox_if.sv
// Producer-side and AMI-side signal bundle of the outbox.
// master = the outbox itself, slave = producers plus AMI consumer.
interface mcse_ami_outbox_if
  import mcse_ami_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ovf_clr;
  logic [NUM_CH-1:0]        ch_overflow;
  logic [DATA_W-1:0]        ami_out;
  logic [CH_W-1:0]          ami_ch;
  logic                     ami_valid;
  logic                     ami_ack;
  logic                     busy;

  modport master (
    input  ch_valid, ch_data, ovf_clr, ami_ack,
    output ch_ready, ch_overflow, ami_out, ami_ch, ami_valid, busy
  );

  modport slave (
    output ch_valid, ch_data, ovf_clr, ami_ack,
    input  ch_ready, ch_overflow, ami_out, ami_ch, ami_valid, busy
  );

endinterface

// File: rtl/mcse_ami_outbox_fifo.sv
// Per-channel synchronous FIFO (DATA_W x DEPTH, DEPTH a power of two) with occupancy count.
// Storage is not reset; only pointers and count are.
module mcse_ami_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/mcse_ami_outbox.sv
// Collects result words from NUM_CH engines and presents them one at a time on AMI (valid/ack).
// Build flag MCSE_AMI_PRIORITY_EN: channel 0 pre-empts round-robin and leaves rr_ptr untouched.
module mcse_ami_outbox
  import mcse_ami_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  mcse_ami_outbox_if.master   bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  ami_state_t        state, state_nx;
  logic [NUM_CH-1:0] full, empty, push, pop, req, ready;
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [DATA_W-1:0] head [NUM_CH];
  logic [CH_W-1:0]   rr_ptr, gnt, gnt_inc;
  logic [MAX_CH-1:0] req_ext;
  logic              do_grant;
  logic [DATA_W-1:0] ami_out_p0;
  logic [CH_W-1:0]   ami_ch_p0;
  logic [NUM_CH-1:0] ovf_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mcse_ami_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (bus.ch_data[i*DATA_W +: DATA_W]),
      .rdata (head[i]),
      .count (cnt[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
    // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
    assign ready[i] = (cnt[i] < CNT_W'(DEPTH));
  end

  assign req  = ~empty;
  assign push = bus.ch_valid & ready;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_CH-1:0] = req;
    gnt = CH_W'(rr_next(req_ext, int'(rr_ptr), NUM_CH));
`ifdef MCSE_AMI_PRIORITY_EN
    if (req[0]) gnt = '0;
`endif
  end

  assign gnt_inc = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
  assign pop     = do_grant ? (NUM_CH'(1) << gnt) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= AMI_IDLE;
    else      state <= state_nx;
  end

  // A new word may be loaded whenever nothing is presented or the presented word is acked.
  always_comb begin
    state_nx = state;
    do_grant = 1'b0;
    case (state)
      AMI_IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          state_nx = AMI_PRESENT;
        end
      end
      AMI_PRESENT: begin
        if (bus.ami_ack) begin
          if (|req) do_grant = 1'b1;
          else      state_nx = AMI_IDLE;
        end
      end
      default: state_nx = AMI_IDLE;
    endcase
  end

  // ---- presentation stage p0 ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ami_out_p0 <= '0;
      ami_ch_p0  <= '0;
      rr_ptr     <= '0;
      ovf_q      <= '0;
    end else begin
      ovf_q <= (ovf_q & ~bus.ovf_clr) | (bus.ch_valid & full);
      if (do_grant) begin
        ami_out_p0 <= head[gnt];
        ami_ch_p0  <= gnt;
`ifdef MCSE_AMI_PRIORITY_EN
        if (gnt != '0) rr_ptr <= gnt_inc;
`else
        rr_ptr <= gnt_inc;
`endif
      end
    end
  end

  assign bus.ch_ready    = ready;
  assign bus.ch_overflow = ovf_q;
  assign bus.ami_out     = ami_out_p0;
  assign bus.ami_ch      = ami_ch_p0;
  assign bus.ami_valid   = (state == AMI_PRESENT);
  assign bus.busy        = (|req) | (state == AMI_PRESENT);

endmodule
